// File: rtl/systolic_feeder_2x2.sv
// Purpose: buffers K load beats of A/B, then drives the skewed W/N edge streams of a 2x2 FP32 array.
// Latency: last accepted beat -> CLEAR -> first FEED cycle (2 edges); FEED start to done = K+1+PE_LAT+1 cycles.
// Backpressure: in_ready is high only in IDLE/LOAD; done holds until done_ack, no beat is dropped or duplicated.
module systolic_feeder_2x2 #(
    parameter int DW     = 32,
    parameter int K      = 2,
    parameter int PE_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a0,
    input  logic [DW-1:0] in_a1,
    input  logic [DW-1:0] in_b0,
    input  logic [DW-1:0] in_b1,
    output logic [DW-1:0] W0,
    output logic [DW-1:0] W1,
    output logic [DW-1:0] N0,
    output logic [DW-1:0] N1,
    output logic          acc_clr,
    output logic          busy,
    output logic          done,
    input  logic          done_ack
);

    // Beat index width, feed step width (0..K) and drain counter width (0..PE_LAT).
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = $clog2(K + 1);
    localparam int CW = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;

    localparam logic [BW-1:0] BEAT_LAST  = BW'(K - 1);
    localparam logic [TW-1:0] FEED_LAST  = TW'(K);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(PE_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [BW-1:0] beat_q;
    logic [TW-1:0] feed_q;
    logic [CW-1:0] drain_q;

    logic [DW-1:0] w0_q, w1_q, n0_q, n1_q;
    logic [DW-1:0] w0_d, w1_d, n0_d, n1_d;
    logic          acc_clr_q, busy_q, done_q;

    // One slot per inner-dimension beat; contents are don't-care after reset.
    logic [DW-1:0] a0_q [K];
    logic [DW-1:0] a1_q [K];
    logic [DW-1:0] b0_q [K];
    logic [DW-1:0] b1_q [K];

    logic          load_fire;
    logic [TW-1:0] feed_nxt;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign load_fire = in_valid && in_ready;
    assign feed_nxt  = feed_q + 1'b1;

    assign W0      = w0_q;
    assign W1      = w1_q;
    assign N0      = n0_q;
    assign N1      = n1_q;
    assign acc_clr = acc_clr_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Capture each accepted beat into the slot selected by the beat counter.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            a0_q[beat_q] <= in_a0;
            a1_q[beat_q] <= in_a1;
            b0_q[beat_q] <= in_b0;
            b1_q[beat_q] <= in_b1;
        end
    end

    // Edge values for FEED step feed_q+1: row/col 0 lead, row/col 1 lag one step; +0.0 outside the window.
    always_comb begin
        w0_d = '0;
        w1_d = '0;
        n0_d = '0;
        n1_d = '0;
        if (feed_q != FEED_LAST) begin
            w1_d = a1_q[feed_q[BW-1:0]];
            n1_d = b1_q[feed_q[BW-1:0]];
            if (feed_nxt != FEED_LAST) begin
                w0_d = a0_q[feed_nxt[BW-1:0]];
                n0_d = b0_q[feed_nxt[BW-1:0]];
            end
        end
    end

    // Control FSM; all array-facing outputs are registered so they only move on clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            feed_q    <= '0;
            drain_q   <= '0;
            w0_q      <= '0;
            w1_q      <= '0;
            n0_q      <= '0;
            n1_q      <= '0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (load_fire) begin
                        if (beat_q == BEAT_LAST) begin
                            state_q   <= S_CLEAR;
                            beat_q    <= '0;
                            acc_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            beat_q  <= beat_q + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q <= S_FEED;
                    feed_q  <= '0;
                    w0_q    <= a0_q[0];
                    n0_q    <= b0_q[0];
                    w1_q    <= '0;
                    n1_q    <= '0;
                end
                S_FEED: begin
                    if (feed_q == FEED_LAST) begin
                        state_q <= S_DRAIN;
                        feed_q  <= '0;
                        drain_q <= '0;
                        w0_q    <= '0;
                        w1_q    <= '0;
                        n0_q    <= '0;
                        n1_q    <= '0;
                    end else begin
                        feed_q <= feed_nxt;
                        w0_q   <= w0_d;
                        w1_q   <= w1_d;
                        n0_q   <= n0_d;
                        n1_q   <= n1_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        drain_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (done_ack) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
